// File: rtl/pcs_pkg.sv
// Shared 100GbE PCS definitions: coded block width, sync headers and the
// PCS IDLE control block used as the fill word.
package pcs_pkg;

  localparam int unsigned NB_DATA_CODED = 66;

  typedef enum logic [1:0] {
    SH_DATA = 2'b01,
    SH_CTRL = 2'b10
  } sync_hdr_e;

  // Control block, block type 0x1E, all eight characters /I/.
  localparam logic [NB_DATA_CODED-1:0] PCS_IDLE = 66'h2_1E00_0000_0000_0000;

endpackage

// File: rtl/clock_comp_tx_fifo.sv
// Synchronous FIFO for clock_comp_tx.
//   i_clock/i_reset : clock, async active-low reset
//   i_clear         : synchronous clear of pointers
//   i_wr/i_wr_data  : push (ignored when full)
//   i_rd            : pop (ignored when empty)
//   o_head          : current head word, combinational
//   o_full/o_empty  : status of the current (pre-edge) contents
module clock_comp_tx_fifo #(
  parameter int unsigned NB_DATA = 66,
  parameter int unsigned NB_ADDR = 5
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_wr,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic               i_rd,
  output logic [NB_DATA-1:0] o_head,
  output logic               o_full,
  output logic               o_empty
);

  localparam int unsigned DEPTH = 1 << NB_ADDR;

  logic [NB_DATA-1:0] mem_q [0:DEPTH-1];
  logic [NB_ADDR:0]   wr_ptr_q, wr_ptr_d;
  logic [NB_ADDR:0]   rd_ptr_q, rd_ptr_d;
  logic               wr_en, rd_en;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  always_comb begin
    o_empty  = (wr_ptr_q == rd_ptr_q);
    o_full   = (wr_ptr_q[NB_ADDR] != rd_ptr_q[NB_ADDR]) &&
               (wr_ptr_q[NB_ADDR-1:0] == rd_ptr_q[NB_ADDR-1:0]);
    wr_en    = i_wr & ~o_full;
    rd_en    = i_rd & ~o_empty;
    o_head   = mem_q[rd_ptr_q[NB_ADDR-1:0]];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + (NB_ADDR+1)'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + (NB_ADDR+1)'(1);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (wr_en && !i_clear) mem_q[wr_ptr_q[NB_ADDR-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/clock_comp_tx.sv
// Transmit-side clock compensation for the 100GbE PCS.
// Reserves N_LANES output slots per alignment period for aligner markers and
// deletes an equal number of full PCS IDLE blocks from the input stream.
//   i_clock, i_reset (async, active-low), i_rf_enable (low = sync clear)
//   i_valid/i_data   : coded input blocks
//   o_valid/o_data   : compensated blocks, one cycle after i_valid
//   o_am_insert      : output slot reserved for a marker (o_data = PCS_IDLE)
//   o_overflow       : sticky, write dropped on full FIFO
//   o_underflow      : sticky, read on empty FIFO substituted PCS_IDLE
module clock_comp_tx #(
  parameter int unsigned NB_DATA_CODED   = pcs_pkg::NB_DATA_CODED,
  parameter int unsigned AM_BLOCK_PERIOD = 16383,
  parameter int unsigned N_LANES         = 20,
  parameter int unsigned NB_ADDR         = 5
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_rf_enable,
  input  logic                     i_valid,
  input  logic [NB_DATA_CODED-1:0] i_data,
  output logic [NB_DATA_CODED-1:0] o_data,
  output logic                     o_valid,
  output logic                     o_am_insert,
  output logic                     o_overflow,
  output logic                     o_underflow
);
  import pcs_pkg::*;

  localparam int unsigned PERIOD = N_LANES * (AM_BLOCK_PERIOD + 1);
  localparam int unsigned CNT_W  = $clog2(PERIOD);
  localparam int unsigned PEND_W = NB_ADDR + 1;
  localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]         N_SLOTS  = CNT_W'(N_LANES);
  localparam logic [NB_DATA_CODED-1:0] IDLE     = NB_DATA_CODED'(PCS_IDLE);

  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [PEND_W-1:0]        pend_q, pend_d;
  logic [NB_DATA_CODED-1:0] data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     am_q, am_d;
  logic                     ovf_q, ovf_d;
  logic                     unf_q, unf_d;

  logic                     am_slot, del, wr, rd;
  logic [NB_DATA_CODED-1:0] fifo_head;
  logic                     fifo_full, fifo_empty;

  always_comb begin
    am_slot = i_valid & (cnt_q < N_SLOTS);
    del     = i_valid & (i_data == IDLE) & (pend_q != '0);
    wr      = i_valid & ~del;
    rd      = i_valid & ~am_slot;
  end

  clock_comp_tx_fifo #(
    .NB_DATA (NB_DATA_CODED),
    .NB_ADDR (NB_ADDR)
  ) u_fifo (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_clear   (~i_rf_enable),
    .i_wr      (wr),
    .i_wr_data (i_data),
    .i_rd      (rd),
    .o_head    (fifo_head),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty)
  );

  always_comb begin
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    data_d  = data_q;
    valid_d = i_valid;
    am_d    = am_slot;
    ovf_d   = ovf_q | (wr & fifo_full);
    unf_d   = unf_q | (rd & fifo_empty);
    if (i_valid) begin
      cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      data_d = (am_slot || fifo_empty) ? IDLE : fifo_head;
    end
    // A slot and a delete in the same cycle cancel out; a delete implies
    // pend_q != 0, so only the increment needs saturation.
    unique case ({am_slot, del})
      2'b10:   if (pend_q != '1) pend_d = pend_q + PEND_W'(1);
      2'b01:   pend_d = pend_q - PEND_W'(1);
      default: pend_d = pend_q;
    endcase
    if (!i_rf_enable) begin
      cnt_d   = '0;
      pend_d  = '0;
      data_d  = IDLE;
      valid_d = 1'b0;
      am_d    = 1'b0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q   <= '0;
      pend_q  <= '0;
      data_q  <= IDLE;
      valid_q <= 1'b0;
      am_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      am_q    <= am_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_comb begin
    o_data      = data_q;
    o_valid     = valid_q;
    o_am_insert = am_q;
    o_overflow  = ovf_q;
    o_underflow = unf_q;
  end

endmodule

// File: tb/tb_clock_comp_tx.sv
module tb_clock_comp_tx;
  import pcs_pkg::*;

  localparam int unsigned NL    = 2;
  localparam int unsigned AMP   = 4;
  localparam int unsigned NA    = 3;
  localparam int unsigned P     = NL * (AMP + 1);
  localparam int unsigned DEPTH = 1 << NA;
  localparam int unsigned PMAX  = (1 << (NA + 1)) - 1;

  typedef struct packed {
    logic        v;
    logic        am;
    logic [65:0] d;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic        i_clock, i_reset, i_rf_enable, i_valid;
  logic [65:0] i_data, o_data;
  logic        o_valid, o_am_insert, o_overflow, o_underflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  exp_t        sb[$];
  logic [65:0] m_fifo[$];
  int unsigned m_cnt, m_pend;
  logic        m_ovf, m_unf, m_ov, m_am;
  logic [65:0] m_od;

  clock_comp_tx #(
    .NB_DATA_CODED   (66),
    .AM_BLOCK_PERIOD (AMP),
    .N_LANES         (NL),
    .NB_ADDR         (NA)
  ) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_rf_enable (i_rf_enable),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_am_insert (o_am_insert),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  function automatic logic [65:0] blk(input int unsigned idx);
    logic [63:0] payload;
    payload = 64'hDA7A_0000_0000_0000 | 64'(idx);
    return {SH_DATA, payload};
  endfunction

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_cnt = 0; m_pend = 0; m_fifo.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_od = PCS_IDLE; m_ov = 1'b0; m_am = 1'b0;
  endtask

  task automatic model(input logic v, input logic [65:0] d, input logic en);
    if (!en) begin
      model_clear();
    end else if (!v) begin
      m_ov = 1'b0; m_am = 1'b0;
    end else begin : valid_cycle
      bit slot, del, full0, empty0;
      slot   = (m_cnt < NL);
      del    = (d == PCS_IDLE) && (m_pend > 0);
      full0  = (m_fifo.size() == DEPTH);
      empty0 = (m_fifo.size() == 0);
      if (slot) m_od = PCS_IDLE;
      else if (empty0) begin m_od = PCS_IDLE; m_unf = 1'b1; end
      else m_od = m_fifo.pop_front();
      if (!del) begin
        if (full0) m_ovf = 1'b1;
        else m_fifo.push_back(d);
      end
      if (slot && !del && m_pend < PMAX) m_pend++;
      else if (del && !slot) m_pend--;
      m_cnt = (m_cnt == P - 1) ? 0 : m_cnt + 1;
      m_ov = 1'b1; m_am = slot;
    end
  endtask

  // Drive one cycle, queue the expected response, then compare after the edge.
  task automatic step(input logic v, input logic [65:0] d, input logic en);
    exp_t e;
    i_valid = v; i_data = d; i_rf_enable = en;
    model(v, d, en);
    e = '{v: m_ov, am: m_am, d: m_od, ovf: m_ovf, unf: m_unf};
    sb.push_back(e);
    @(posedge i_clock); #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 66'd1, 66'd0);
    end else begin
      e = sb.pop_front();
      chk("o_valid", 66'(o_valid), 66'(e.v));
      chk("o_am_insert", 66'(o_am_insert), 66'(e.am));
      chk("o_data", o_data, e.d);
      chk("o_overflow", 66'(o_overflow), 66'(e.ovf));
      chk("o_underflow", 66'(o_underflow), 66'(e.unf));
    end
  endtask

  // Asynchronous reset applied away from the clock edge; outputs must
  // respond before the next edge.
  task automatic do_reset();
    i_valid = 1'b0; i_data = PCS_IDLE; i_rf_enable = 1'b1;
    i_reset = 1'b0;
    #1;
    chk("rst_o_data", o_data, PCS_IDLE);
    chk("rst_o_valid", 66'(o_valid), 66'd0);
    chk("rst_o_am_insert", 66'(o_am_insert), 66'd0);
    chk("rst_o_overflow", 66'(o_overflow), 66'd0);
    chk("rst_o_underflow", 66'(o_underflow), 66'd0);
    model_clear();
    sb.delete();
    @(posedge i_clock); #1;
    i_reset = 1'b1;
  endtask

  task automatic idle_run();
    for (int i = 0; i < 22; i++) begin
      step(1'b1, PCS_IDLE, 1'b1);
      chk("idle_am_pos", 66'(o_am_insert), 66'((i % P) < NL));
      chk("idle_data", o_data, PCS_IDLE);
      chk("idle_ovf", 66'(o_overflow), 66'd0);
    end
  endtask

  initial begin
    int unsigned k, vj;
    i_reset = 1'b1; i_rf_enable = 1'b1; i_valid = 1'b0; i_data = PCS_IDLE;
    model_clear();
    #2;

    // Continuous idles after reset.
    do_reset();
    idle_run();

    // Repeating D0..D3, IDLE, IDLE: data order preserved.
    do_reset();
    k = 0;
    for (int i = 0; i < 36; i++) begin
      step(1'b1, ((i % 6) < 4) ? blk(i % 6) : PCS_IDLE, 1'b1);
      if (o_valid && !o_am_insert && o_data != PCS_IDLE) begin
        chk("order", o_data, blk(k % 4));
        k++;
      end
    end
    chk("order_count_min", 66'(k >= 18), 66'd1);

    // Continuous data: occupancy grows 2 per period, overflow in period 4.
    do_reset();
    for (int i = 0; i < 45; i++) begin
      step(1'b1, blk(i + 100), 1'b1);
      chk("ovf_time", 66'(o_overflow), 66'(i >= 32));
    end

    // Alternating valid: slots every 10th valid cycle, counters frozen otherwise.
    do_reset();
    vj = 0;
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 0) begin
        step(1'b1, (i % 4 == 0) ? blk(i) : PCS_IDLE, 1'b1);
        chk("tog_am_pos", 66'(o_am_insert), 66'((vj % P) < NL));
        vj++;
      end else begin
        step(1'b0, blk(i), 1'b1);
        chk("tog_invalid", 66'({o_valid, o_am_insert}), 66'd0);
      end
    end

    // One-cycle rf_enable drop mid-period.
    do_reset();
    for (int i = 0; i < 35; i++) step(1'b1, blk(i + 200), 1'b1);
    step(1'b1, blk(300), 1'b0);
    chk("clr_data", o_data, PCS_IDLE);
    chk("clr_flags", 66'({o_overflow, o_underflow}), 66'd0);
    step(1'b1, blk(301), 1'b1);
    chk("clr_am0", 66'(o_am_insert), 66'd1);
    step(1'b1, blk(302), 1'b1);
    chk("clr_am1", 66'(o_am_insert), 66'd1);
    step(1'b1, blk(303), 1'b1);
    chk("clr_first_data", o_data, blk(301));

    // Asynchronous reset mid-period, then behaviour as after the first reset.
    for (int i = 0; i < 4; i++) step(1'b1, blk(i + 400), 1'b1);
    do_reset();
    idle_run();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
